// File: rtl/pixelscale_pkg.sv
// Shared types and elaboration-time helpers for the bilinear resample sequencer.
package pixelscale_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_WAIT,
    ST_FLUSH
  } state_t;

  localparam int STEPS = 4;

  // Fixed-point source distance between neighbouring output pixels, truncated.
  function automatic int unsigned scale_step(int unsigned src, int unsigned dst, int unsigned prec);
    longint unsigned num;
    num = 64'(src - 1) << prec;
    return 32'(num / 64'(dst - 1));
  endfunction

  function automatic int acc_width(int n, int m, int prec);
    return prec + ((n > m) ? n : m) + 1;
  endfunction

endpackage

// File: rtl/resample_sequencer_if.sv
// Output pixel stream: one-entry valid/ready register with a last-sample flag.
interface resample_sequencer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/resample_sequencer_coord_stepper.sv
// One axis of the source-coordinate walk: fixed-point accumulator, integer/fraction split, edge clamp.
module coord_stepper #(
  parameter int          IW   = 8,
  parameter int          PREC = 16,
  parameter int          AW   = 25,
  parameter int          SRC  = 200,
  parameter int unsigned STEP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [IW-1:0]   coord,
  output logic [PREC-1:0] frac
);
  localparam int HW = AW - PREC;
  localparam logic [HW-1:0] MAX_INT   = HW'(SRC - 1);
  localparam logic [IW-1:0] MAX_COORD = IW'(SRC - 1);

  logic [AW-1:0] acc_reg;
  logic [HW-1:0] int_part;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_reg <= '0;
    end else if (inc) begin
      acc_reg <= acc_reg + AW'(STEP);
    end
  end

  assign int_part = acc_reg[AW-1:PREC];

  // Past the last source sample, pin to the edge with zero fraction.
  always_comb begin
    coord = int_part[IW-1:0];
    frac  = acc_reg[PREC-1:0];
    if (int_part > MAX_INT) begin
      coord = MAX_COORD;
      frac  = '0;
    end
  end
endmodule

// File: rtl/resample_sequencer.sv
// Walks output pixels/channels in raster order, drives the 4-step transform sequence
// and streams each interpolated sample through a one-entry valid/ready register.
module resample_sequencer
  import pixelscale_pkg::*;
#(
  parameter int N         = 8,
  parameter int M         = 8,
  parameter int precision = 16,
  parameter int W_in      = 200,
  parameter int H_in      = 200,
  parameter int W_out     = 400,
  parameter int H_out     = 400,
  parameter int CHANNEL   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [N-1:0]         x_0,
  output logic [M-1:0]         y_0,
  output logic [precision-1:0] a,
  output logic [precision-1:0] b,
  output logic [1:0]           counter,
  output logic [2:0]           counter1,
  input  logic [7:0]           v,
  resample_sequencer_if.master out_if
);
  localparam int          AW = acc_width(N, M, precision);
  localparam int unsigned SX = scale_step(W_in, W_out, precision);
  localparam int unsigned SY = scale_step(H_in, H_out, precision);
  localparam int          XW = $clog2(W_out);
  localparam int          YW = $clog2(H_out);
  localparam logic [XW-1:0] X_LAST    = XW'(W_out - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(H_out - 1);
  localparam logic [1:0]    CH_LAST   = 2'(CHANNEL - 1);
  localparam logic [1:0]    STEP_LAST = 2'(STEPS - 1);

  state_t        state_reg, state_next;
  logic [1:0]    step_reg, step_next;
  logic [1:0]    ch_reg, ch_next;
  logic [XW-1:0] xi_reg, xi_next;
  logic [YW-1:0] yi_reg, yi_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          last_reg, last_next;
  logic          done_reg, done_next;
  logic          x_clr, x_inc, y_clr, y_inc;
  logic          can_capture, ch_last, frame_last;

  coord_stepper #(.IW(N), .PREC(precision), .AW(AW), .SRC(W_in), .STEP(SX)) x_stepper (
    .clk(clk), .rst(rst), .clr(x_clr), .inc(x_inc), .coord(x_0), .frac(a)
  );

  coord_stepper #(.IW(M), .PREC(precision), .AW(AW), .SRC(H_in), .STEP(SY)) y_stepper (
    .clk(clk), .rst(rst), .clr(y_clr), .inc(y_inc), .coord(y_0), .frac(b)
  );

  assign can_capture = !valid_reg || out_if.out_ready;
  assign ch_last     = (ch_reg == CH_LAST);
  assign frame_last  = ch_last && (xi_reg == X_LAST) && (yi_reg == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      ch_reg    <= '0;
      xi_reg    <= '0;
      yi_reg    <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      ch_reg    <= ch_next;
      xi_reg    <= xi_next;
      yi_reg    <= yi_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    ch_next    = ch_reg;
    xi_next    = xi_reg;
    yi_next    = yi_reg;
    data_next  = data_reg;
    valid_next = valid_reg && !out_if.out_ready;
    last_next  = last_reg && !(valid_reg && out_if.out_ready);
    done_next  = 1'b0;
    x_clr      = 1'b0;
    x_inc      = 1'b0;
    y_clr      = 1'b0;
    y_inc      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        step_next = '0;
        ch_next   = '0;
        xi_next   = '0;
        yi_next   = '0;
        x_clr     = 1'b1;
        y_clr     = 1'b1;
        if (start) state_next = ST_STEP;
      end
      ST_STEP: begin
        if (step_reg != STEP_LAST) begin
          step_next = step_reg + 2'd1;
        end else begin
          step_next = '0;
          if (can_capture) begin
            data_next  = v;
            valid_next = 1'b1;
            last_next  = frame_last;
            if (!ch_last) begin
              ch_next = ch_reg + 2'd1;
            end else begin
              ch_next = '0;
              if (frame_last) begin
                state_next = ST_FLUSH;
                xi_next    = '0;
                yi_next    = '0;
                x_clr      = 1'b1;
                y_clr      = 1'b1;
              end else if (xi_reg == X_LAST) begin
                xi_next = '0;
                x_clr   = 1'b1;
                yi_next = yi_reg + YW'(1);
                y_inc   = 1'b1;
              end else begin
                xi_next = xi_reg + XW'(1);
                x_inc   = 1'b1;
              end
            end
          end else begin
            // The stall disturbs the transform accumulator, so all 4 steps rerun later.
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        step_next = '0;
        if (can_capture) state_next = ST_STEP;
      end
      ST_FLUSH: begin
        if (valid_reg && out_if.out_ready) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy              = (state_reg != ST_IDLE);
  assign done              = done_reg;
  assign counter           = ch_reg;
  assign counter1          = {1'b0, step_reg};
  assign out_if.out_data   = data_reg;
  assign out_if.out_valid  = valid_reg;
  assign out_if.out_last   = last_reg;
endmodule

// File: tb/tb_resample_sequencer.sv
// Bench for resample_sequencer on a 4x4x3 source upscaled to 7x7, with a behavioural transform model.
module tb_resample_sequencer;
  localparam int W_IN      = 4;
  localparam int H_IN      = 4;
  localparam int W_OUT     = 7;
  localparam int H_OUT     = 7;
  localparam int CH        = 3;
  localparam int NSAMP     = W_OUT * H_OUT * CH;
  localparam int SXY       = 32768;
  localparam int FRAME_CYC = 4 * NSAMP + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [7:0]  x_0, y_0;
  logic [15:0] a, b;
  logic [1:0]  counter;
  logic [2:0]  counter1;
  logic [7:0]  v;

  resample_sequencer_if out_if();

  resample_sequencer #(
    .N(8), .M(8), .precision(16), .W_in(W_IN), .H_in(H_IN),
    .W_out(W_OUT), .H_out(H_OUT), .CHANNEL(CH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_0(x_0), .y_0(y_0), .a(a), .b(b), .counter(counter), .counter1(counter1),
    .v(v), .out_if(out_if)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } exp_t;
  typedef struct { int x0; int fa; int y0; int fb; int c; } cap_t;
  typedef struct { int px; int py; int x0; int fa; int y0; int fb; } coord_vec_t;

  exp_t       exp_q[$];
  cap_t       cap_q[$];
  logic [7:0] stream_q[$];
  logic [7:0] ref_stream[$];
  exp_t       mon_e;
  cap_t       mon_c;
  coord_vec_t vecs[10];

  int n_checks = 0, n_pass = 0;
  int n_samples = 0, n_done = 0, gap_err = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0;
  bit gap_en = 1'b0;
  logic [2:0] prev_c1 = 3'd0;
  logic       prev_busy = 1'b0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic int img(int x, int y, int c);
    int xc, yc;
    xc = (x > W_IN - 1) ? W_IN - 1 : x;
    yc = (y > H_IN - 1) ? H_IN - 1 : y;
    return (xc * 37 + yc * 71 + c * 90 + 13) & 255;
  endfunction

  // Weighted corner contribution for interpolation step k (weights sum to 2^32).
  function automatic longint term(int x0, int y0, int fa, int fb, int c, int k);
    longint wa0, wa1, wb0, wb1;
    wa0 = 65536 - fa; wa1 = fa; wb0 = 65536 - fb; wb1 = fb;
    case (k)
      0:       return wa0 * wb0 * img(x0, y0, c);
      1:       return wa1 * wb0 * img(x0 + 1, y0, c);
      2:       return wa0 * wb1 * img(x0, y0 + 1, c);
      default: return wa1 * wb1 * img(x0 + 1, y0 + 1, c);
    endcase
  endfunction

  function automatic longint pack(int x0, int fa, int y0, int fb);
    return (longint'(x0) << 48) | (longint'(fa) << 32) | (longint'(y0) << 16) | longint'(fb);
  endfunction

  // Transform model: accumulates over steps 0..2, full value visible during step 3.
  longint tacc = 0;
  longint vfull;
  always @(posedge clk) begin
    if (counter1 == 3'd0) tacc <= term(int'(x_0), int'(y_0), int'(a), int'(b), int'(counter), 0);
    else if (counter1 == 3'd1) tacc <= tacc + term(int'(x_0), int'(y_0), int'(a), int'(b), int'(counter), 1);
    else if (counter1 == 3'd2) tacc <= tacc + term(int'(x_0), int'(y_0), int'(a), int'(b), int'(counter), 2);
  end
  always_comb vfull = tacc + term(int'(x_0), int'(y_0), int'(a), int'(b), int'(counter), 3);
  assign v = (counter1 == 3'd3) ? 8'(vfull >> 32) : 8'hA5;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_if.out_valid && out_if.out_ready) begin
        $display("sample %0d data=0x%02h last=%0b", n_samples, out_if.out_data, out_if.out_last);
        if (exp_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("sample%0d_data", n_samples), out_if.out_data, mon_e.data);
          check($sformatf("sample%0d_last", n_samples), out_if.out_last, mon_e.last);
        end
        stream_q.push_back(out_if.out_data);
        n_samples++;
      end
      if (busy && counter1 == 3'd3 && (!out_if.out_valid || out_if.out_ready)) begin
        mon_c.x0 = int'(x_0); mon_c.fa = int'(a); mon_c.y0 = int'(y_0); mon_c.fb = int'(b);
        mon_c.c = int'(counter);
        cap_q.push_back(mon_c);
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (gap_en && busy && prev_busy && counter1 != ((prev_c1 + 3'd1) & 3'd3)) gap_err++;
    end
    prev_c1   = counter1;
    prev_busy = busy;
  end

  task automatic push_frame();
    for (int k = 0; k < NSAMP; k++) begin
      int c, p, px, py, xacc, yacc, x0, fa, y0, fb;
      longint s;
      exp_t e;
      c = k % CH; p = k / CH; px = p % W_OUT; py = p / W_OUT;
      xacc = px * SXY; yacc = py * SXY;
      x0 = xacc >> 16; fa = xacc & 65535;
      y0 = yacc >> 16; fb = yacc & 65535;
      if (x0 > W_IN - 1) begin x0 = W_IN - 1; fa = 0; end
      if (y0 > H_IN - 1) begin y0 = H_IN - 1; fb = 0; end
      s = term(x0, y0, fa, fb, c, 0) + term(x0, y0, fa, fb, c, 1)
        + term(x0, y0, fa, fb, c, 2) + term(x0, y0, fa, fb, c, 3);
      e.data = 8'(s >> 32);
      e.last = (k == NSAMP - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic begin_frame(input bit gap);
    n_samples = 0; n_done = 0; gap_err = 0;
    stream_q.delete(); cap_q.delete();
    gap_en = gap;
    push_frame();
    start = 1'b1;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input bit rnd, input bit spam);
    int it;
    it = 0;
    while (n_done == 0 && it < 3000) begin
      @(posedge clk); #1;
      if (rnd) out_if.out_ready = 1'($urandom_range(0, 1));
      if (spam) start = (it == 50 || it == 200 || it == 400);
      it++;
    end
    start = 1'b0;
    out_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_count"}, n_done, 1);
    check({name, "_samples"}, n_samples, NSAMP);
    check({name, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic compare_stream(input string name);
    int errs;
    errs = 0;
    check({name, "_stream_len"}, stream_q.size(), ref_stream.size());
    for (int i = 0; i < stream_q.size() && i < ref_stream.size(); i++)
      if (stream_q[i] != ref_stream[i]) errs++;
    check({name, "_stream_diff"}, errs, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int it, idx, errs;
    logic [7:0] d0;
    vecs[0] = '{0, 0, 0, 0,     0, 0};
    vecs[1] = '{1, 0, 0, 32768, 0, 0};
    vecs[2] = '{2, 0, 1, 0,     0, 0};
    vecs[3] = '{3, 0, 1, 32768, 0, 0};
    vecs[4] = '{4, 0, 2, 0,     0, 0};
    vecs[5] = '{5, 0, 2, 32768, 0, 0};
    vecs[6] = '{6, 0, 3, 0,     0, 0};
    vecs[7] = '{3, 1, 1, 32768, 0, 32768};
    vecs[8] = '{0, 2, 0, 0,     1, 0};
    vecs[9] = '{6, 6, 3, 0,     3, 0};

    out_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_coords", {x_0, y_0, a, b}, 0);
    check("reset_ctrl", {busy, done, counter, counter1, out_if.out_valid, out_if.out_last, out_if.out_data}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame A: ready held high, reference stream and coordinate sweep.
    begin_frame(1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    check("A_lat_step0", {busy, counter1}, {1'b1, 3'd0});
    repeat (3) @(posedge clk);
    #1;
    check("A_lat_step3", {counter1, out_if.out_valid}, {3'd3, 1'b0});
    @(posedge clk); #1;
    check("A_lat_valid", out_if.out_valid, 1);
    wait_done("A", 1'b0, 1'b0);
    check("A_frame_cycles", done_cyc - start_cyc, FRAME_CYC);
    check("A_busy_after_done", busy, 0);
    check("A_step_gaps", gap_err, 0);
    gap_en = 1'b0;
    ref_stream = stream_q;
    for (int i = 0; i < 10; i++) begin
      idx = (vecs[i].py * W_OUT + vecs[i].px) * CH;
      if (idx < cap_q.size())
        check($sformatf("A_coord_px%0d_py%0d", vecs[i].px, vecs[i].py),
              pack(cap_q[idx].x0, cap_q[idx].fa, cap_q[idx].y0, cap_q[idx].fb),
              pack(vecs[i].x0, vecs[i].fa, vecs[i].y0, vecs[i].fb));
      else
        check($sformatf("A_coord_px%0d_py%0d_missing", vecs[i].px, vecs[i].py), -1, 0);
    end
    errs = 0;
    for (int k = 0; k < cap_q.size(); k++) if (cap_q[k].c != k % CH) errs++;
    check("A_channel_order", errs, 0);

    // Frame B: 10-cycle stall right after the first capture.
    begin_frame(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    it = 0;
    while (!out_if.out_valid && it < 20) begin
      @(posedge clk); #1;
      it++;
    end
    check("B_first_valid", out_if.out_valid, 1);
    out_if.out_ready = 1'b0;
    d0 = out_if.out_data;
    repeat (7) @(posedge clk);
    #1;
    check("B_wait_state", {busy, counter1}, {1'b1, 3'd0});
    repeat (3) @(posedge clk);
    #1;
    check("B_hold", {out_if.out_valid, out_if.out_data}, {1'b1, d0});
    out_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("B_redo_step0", counter1, 0);
    @(posedge clk); #1;
    check("B_redo_step1", counter1, 1);
    wait_done("B", 1'b0, 1'b0);
    compare_stream("B");

    // Frame C: random backpressure.
    begin_frame(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("C", 1'b1, 1'b0);
    compare_stream("C");

    // Frame D: reset after sample 20 abandons the frame.
    begin_frame(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    it = 0;
    while (n_samples < 20 && it < 500) begin
      @(posedge clk); #1;
      it++;
    end
    check("D_reached_20", n_samples, 20);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("D_reset_coords", {x_0, y_0, a, b}, 0);
    check("D_reset_ctrl", {busy, done, counter, counter1, out_if.out_valid, out_if.out_last, out_if.out_data}, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("D_no_done", n_done, 0);

    // Frame E: restart from (0,0) with extra start pulses while busy.
    begin_frame(1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("E", 1'b0, 1'b1);
    compare_stream("E");
    if (cap_q.size() > 0)
      check("E_first_coord", pack(cap_q[0].x0, cap_q[0].fa, cap_q[0].y0, cap_q[0].fb), 0);
    else
      check("E_first_coord_missing", -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/resample_sequencer.md
# resample_sequencer

Sequencer for the bilinear `transform` datapath. On `start` it walks every output pixel of a `W_out`×`H_out` image in raster order and every channel within each pixel. For each sample it computes the source coordinate in fixed point and drives the 4-step interpolation sequence into `transform`. It then captures `transform.v` into a one-entry output register and emits a valid/ready pixel stream. It sits between the frame-level control and the `transform` instance.

## Interface
- `N`, 8: X coordinate width, shared with `transform`.
- `M`, 8: Y coordinate width.
- `precision`, 16: fractional bits of `a`/`b`.
- `W_in`, 200: source width.
- `H_in`, 200: source height.
- `W_out`, 400: output width, must be ≥2.
- `H_out`, 400: output height, must be ≥2.
- `CHANNEL`, 1: channels per pixel, 1..4.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle frame start; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the final sample is accepted downstream.
- `x_0` out N, `y_0` out M: integer source coordinate, to `transform`.
- `a` out precision, `b` out precision: fractional source coordinate, to `transform`.
- `counter` out 2: channel select, to `transform`.
- `counter1` out 3: interpolation step, to `transform`.
- `v` in 8: interpolated value from `transform`.
- `out_data` out 8: captured sample.
- `out_valid` out 1: `out_data` holds a sample.
- `out_ready` in 1: downstream accept.
- `out_last` out 1: qualifies the final sample of the frame.

## Operation
- Scale constants, computed at elaboration:
  - `SX = ((W_in-1) << precision) / (W_out-1)`, truncated.
  - `SY = ((H_in-1) << precision) / (H_out-1)`, truncated.
- Coordinate accumulators:
  - `xacc` and `yacc` are `precision+max(N,M)+1` bits wide.
  - `x_0 = xacc >> precision` and `a = xacc[precision-1:0]`; likewise `y_0`/`b` from `yacc`.
  - If the integer part exceeds `W_in-1` (or `H_in-1`), output `W_in-1` (or `H_in-1`) with fraction 0.
- Raster walk:
  - Per pixel: `xacc += SX`.
  - At end of row: `xacc = 0`, `yacc += SY`.
  - Coordinates are held constant across all channels and steps of a pixel.
- FSM states:
  - IDLE: all counters and accumulators zero. `start` → STEP.
  - STEP: `counter1` runs 0,1,2,3 on consecutive cycles. During step 3, `v` is the complete interpolated value.
    - At step 3, if the output register is empty or draining this cycle (`out_valid && out_ready`), capture `v` into `out_data`, set `out_valid`, and advance channel/pixel.
    - Otherwise go to WAIT without capturing.
    - The capture of the frame's last sample goes to FLUSH instead of advancing.
  - WAIT: `counter1` driven 0; coordinates and channel unchanged. When `out_valid` drops or drains, go to STEP at step 0 and redo all 4 steps, since the `transform` accumulator was disturbed.
  - FLUSH: wait for the final handshake, then pulse `done` for one cycle → IDLE.
- Advance order: `counter` 0..CHANNEL-1, then x, then y.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a new capture happens in the same cycle.
  - `out_data`, `out_valid` and `out_last` are stable while `out_valid && !out_ready`.
- `start` while `busy` is ignored.

## Timing
- Reset values: every output is 0. FSM goes to IDLE and accumulators clear. Reset mid-frame abandons the frame: no `done`, and `out_valid` is dropped.
- `start` in cycle t → STEP with `counter1=0` at t+1, first capture at the end of t+4, `out_valid` high at t+5.
- With `out_ready` held high, one sample per 4 cycles with no bubbles; a frame takes `4·W_out·H_out·CHANNEL` cycles plus 2.
- A stall costs the stall length plus 4 cycles of redone steps.
- `done` is high in the cycle after the final handshake; `busy` falls in that same cycle.

## Structure
- Shared package `pixelscale_pkg` holds:
  - the state enumeration;
  - `STEPS = 4`;
  - the `SX`/`SY` computation function;
  - the accumulator width function.
- Optional sub-module `coord_stepper`: one instance per axis, covering accumulate, integer/fraction split and clamp. Everything else is flat.

## Test plan
- Coordinate sweep, `W_in=H_in=4`, `W_out=H_out=7`, `precision=16`, `CHANNEL=1`, `out_ready=1`: `SX=SY=32768`. Row 0 produces `(x_0,a)` = (0,0), (0,32768), (1,0) … (3,0). `yacc` steps by one half per row. The frame has 49 samples, `out_last` is set on the 49th only, and `done` pulses exactly once.
- Step sequence: `counter1` reads 0,1,2,3,0,1,… with no gaps. With `CHANNEL=3`, `counter` goes 0,0,0,0,1,1,1,1,2,2,2,2 per pixel. `out_data` equals the reference-model bilinear value for a known `image.hex`.
- Backpressure: hold `out_ready=0` for 10 cycles after the first capture. Expect WAIT, `out_data` stable, step 0 redone after release, and no sample lost or duplicated (sequence compared with the no-stall run).
- Random `out_ready` (50%) over a full 7×7×3 frame: the output stream is bit-identical to the `out_ready=1` run.
- Assert `rst` at mid-frame sample 20. The next cycle shows all outputs 0 and IDLE. A new `start` reproduces the frame from (0,0).
- `start` pulses while busy are ignored: exactly one `done`, and the sample count equals `W_out·H_out·CHANNEL`.
